// File: rtl/xf100_exu_regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : xf100_exu_regfile_mp_if
// Description : Read, write and scoreboard signals of the XF100 EXU
//               multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface xf100_exu_regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int c_IDXW = $clog2(NREG);

    logic [NRD-1:0]        rd_en;
    logic [NRD*c_IDXW-1:0] rd_idx;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [NRD-1:0]        rd_busy;

    logic [NWR-1:0]        wr_en;
    logic [NWR*c_IDXW-1:0] wr_idx;
    logic [NWR*XLEN-1:0]   wr_data;

    logic                  sb_set_en;
    logic [c_IDXW-1:0]     sb_set_idx;
    logic [c_IDXW:0]       sb_cnt;

    // Decode/issue and writeback side.
    modport master (
        output rd_en, rd_idx, wr_en, wr_idx, wr_data, sb_set_en, sb_set_idx,
        input  rd_data, rd_busy, sb_cnt
    );

    // Register file side.
    modport slave (
        input  rd_en, rd_idx, wr_en, wr_idx, wr_data, sb_set_en, sb_set_idx,
        output rd_data, rd_busy, sb_cnt
    );
endinterface
`default_nettype wire

// File: rtl/xf100_exu_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : xf100_exu_regfile_mp
// Description : NRD-read / NWR-write integer register file with hard-wired
//               x0, optional write-to-read bypass and a busy-bit scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module xf100_exu_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    xf100_exu_regfile_mp_if.slave      bus
);
    localparam int c_IDXW = $clog2(NREG);

    logic [XLEN-1:0]   r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [c_IDXW:0]   r_sb_cnt;

    logic [NREG-1:0]   w_wr_hit;
    logic [XLEN-1:0]   w_wr_val [NREG];
    logic [c_IDXW-1:0] w_widx;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_busy_nxt;
    logic [c_IDXW:0]   w_cnt_nxt;

    // Merge all write ports per register; ascending scan lets the highest
    // port index overwrite lower ones. x0 never registers a hit.
    always_comb begin
        w_wr_hit = '0;
        w_widx   = '0;
        for (int i = 0; i < NREG; i++) begin
            w_wr_val[i] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            w_widx = bus.wr_idx[j*c_IDXW +: c_IDXW];
            if (bus.wr_en[j] && (w_widx != '0)) begin
                w_wr_hit[w_widx] = 1'b1;
                w_wr_val[w_widx] = bus.wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Set is applied after clear so a freshly issued producer wins.
    always_comb begin
        w_set = '0;
        if (bus.sb_set_en && (bus.sb_set_idx != '0)) begin
            w_set[bus.sb_set_idx] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_wr_hit) | w_set;
        w_busy_nxt[0] = 1'b0;
        w_cnt_nxt     = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + (c_IDXW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy   <= '0;
            r_sb_cnt <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_wr_hit[i]) begin
                    r_regs[i] <= w_wr_val[i];
                end
            end
            r_busy   <= w_busy_nxt;
            r_sb_cnt <= w_cnt_nxt;
        end
    end

    assign bus.sb_cnt = r_sb_cnt;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [c_IDXW-1:0] w_idx;
        logic              w_live;
        logic              w_byp;

        assign w_idx  = bus.rd_idx[k*c_IDXW +: c_IDXW];
        assign w_live = bus.rd_en[k] && (w_idx != '0);
        assign w_byp  = (BYPASS != 0) && w_wr_hit[w_idx];

        assign bus.rd_data[k*XLEN +: XLEN] = !w_live ? '0 :
                                             w_byp   ? w_wr_val[w_idx] :
                                                       r_regs[w_idx];
        assign bus.rd_busy[k] = w_live && r_busy[w_idx] && !w_byp;
    end
endmodule
`default_nettype wire
